// File: rtl/alu_exec_fsm.sv
// ALU instruction sequencer: runs one Ri op (Rj|imm) -> Ri instruction per start,
// strobing register-file reads/writes, the ALU operand/result ports and the shared bus.
module alu_exec_fsm #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int IDX_W  = 4,
    parameter int OPC_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              wb_en,
    input  logic [OPC_W-1:0]  op,
    input  logic [IDX_W-1:0]  ri,
    input  logic [IDX_W-1:0]  rj,
    input  logic [DATA_W-1:0] imm,
    output logic [NREG-1:0]   reg_read,
    output logic [NREG-1:0]   reg_write,
    output logic [OPC_W-1:0]  alu_op,
    output logic              alu_out_en,
    output logic              alu_write_in1,
    output logic              alu_write_in2,
    output logic              alu_read,
    output logic [DATA_W-1:0] out_to_bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IN1  = 3'd1,
        S_IN2  = 3'd2,
        S_EVAL = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // One extra bit so NREG = 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0] NREG_L = (IDX_W + 1)'(NREG);

    state_t              state_q, state_d;
    logic                mode_q, wb_q, err_q;
    logic [OPC_W-1:0]    op_q;
    logic [IDX_W-1:0]    ri_q, rj_q;
    logic [DATA_W-1:0]   imm_q;
    logic                start_err;
    logic                accept;
    logic                bus_en;
    logic [NREG-1:0]     ri_hot, rj_hot;

    assign start_err = ({1'b0, ri} >= NREG_L) || (!mode && ({1'b0, rj} >= NREG_L));
    assign accept    = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            wb_q   <= 1'b0;
            err_q  <= 1'b0;
            op_q   <= '0;
            ri_q   <= '0;
            rj_q   <= '0;
            imm_q  <= '0;
        end else if (accept) begin
            mode_q <= mode;
            wb_q   <= wb_en;
            err_q  <= start_err;
            op_q   <= op;
            ri_q   <= ri;
            rj_q   <= rj;
            imm_q  <= imm;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = start_err ? S_FIN : S_IN1;
            S_IN1:   state_d = S_IN2;
            S_IN2:   state_d = S_EVAL;
            S_EVAL:  state_d = wb_q ? S_OUT : S_FIN;
            S_OUT:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Captured indices are range-checked at capture, so these never see an out-of-range value in use.
    always_comb begin
        ri_hot = '0;
        rj_hot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ri_q == IDX_W'(i)) ri_hot[i] = 1'b1;
            if (rj_q == IDX_W'(i)) rj_hot[i] = 1'b1;
        end
    end

    always_comb begin
        reg_read      = '0;
        reg_write     = '0;
        alu_op        = '0;
        alu_out_en    = 1'b0;
        alu_write_in1 = 1'b0;
        alu_write_in2 = 1'b0;
        alu_read      = 1'b0;
        bus_en        = 1'b0;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
        err           = 1'b0;
        case (state_q)
            S_IN1: begin
                reg_read      = ri_hot;
                alu_write_in1 = 1'b1;
            end
            S_IN2: begin
                alu_write_in2 = 1'b1;
                if (mode_q) bus_en   = 1'b1;
                else        reg_read = rj_hot;
            end
            S_EVAL: begin
                alu_out_en = 1'b1;
                alu_op     = op_q;
            end
            S_OUT: begin
                alu_read  = 1'b1;
                reg_write = ri_hot;
            end
            S_FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign out_to_bus = bus_en ? imm_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_alu_exec_fsm.sv
// Randomized + directed bench for alu_exec_fsm against a per-instruction trace model.
module tb_alu_exec_fsm;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 4;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, mode = 1'b0, wb_en = 1'b0;
    logic [OW-1:0] op = '0;
    logic [IW-1:0] ri = '0, rj = '0;
    logic [DW-1:0] imm = '0;
    logic [NR-1:0] reg_read, reg_write;
    logic [OW-1:0] alu_op;
    logic          alu_out_en, alu_write_in1, alu_write_in2, alu_read, busy, done, err;
    wire  [DW-1:0] out_to_bus;

    alu_exec_fsm #(.DATA_W(DW), .NREG(NR), .IDX_W(IW), .OPC_W(OW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .wb_en(wb_en), .op(op),
        .ri(ri), .rj(rj), .imm(imm), .reg_read(reg_read), .reg_write(reg_write),
        .alu_op(alu_op), .alu_out_en(alu_out_en), .alu_write_in1(alu_write_in1),
        .alu_write_in2(alu_write_in2), .alu_read(alu_read), .out_to_bus(out_to_bus),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int n_done_seen = 0, n_done_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bus_is_z();
        return (out_to_bus === {DW{1'bz}}) || (out_to_bus === '0);
    endfunction

    // Expected outputs for one cycle.
    typedef struct packed {
        logic [NR-1:0] rd;
        logic [NR-1:0] wr;
        logic [OW-1:0] aop;
        logic          oen, w1, w2, ar, drv, bsy, dn, er;
        logic [DW-1:0] bus;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;
    bit   cur_idle = 1'b1;

    function automatic void push_instr(logic m, logic w, logic [OW-1:0] o,
                                       logic [IW-1:0] a, logic [IW-1:0] b, logic [DW-1:0] im);
        exp_t e;
        bit bad = (int'(a) >= NR) || (!m && int'(b) >= NR);
        e = '0; e.bsy = 1'b1;
        if (bad) begin
            e.dn = 1'b1; e.er = 1'b1; q.push_back(e);
            return;
        end
        e.rd = NR'(1) << a; e.w1 = 1'b1; q.push_back(e);
        e = '0; e.bsy = 1'b1; e.w2 = 1'b1;
        if (m) begin e.drv = 1'b1; e.bus = im; end
        else e.rd = NR'(1) << b;
        q.push_back(e);
        e = '0; e.bsy = 1'b1; e.oen = 1'b1; e.aop = o; q.push_back(e);
        if (w) begin
            e = '0; e.bsy = 1'b1; e.ar = 1'b1; e.wr = NR'(1) << a; q.push_back(e);
        end
        e = '0; e.bsy = 1'b1; e.dn = 1'b1; q.push_back(e);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            if (cur_idle && start) push_instr(mode, wb_en, op, ri, rj, imm);
            if (q.size() > 0) begin cur = q.pop_front(); cur_idle = 1'b0; end
            else begin cur = '0; cur_idle = 1'b1; end
        end
    end

    always @(negedge reset) begin
        q.delete();
        cur = '0;
        cur_idle = 1'b1;
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(cur.bsy));
        chk("done", 32'(done), 32'(cur.dn));
        chk("err", 32'(err), 32'(cur.er));
        chk("reg_read", 32'(reg_read), 32'(cur.rd));
        chk("reg_write", 32'(reg_write), 32'(cur.wr));
        chk("alu_op", 32'(alu_op), 32'(cur.aop));
        chk("alu_out_en", 32'(alu_out_en), 32'(cur.oen));
        chk("alu_write_in1", 32'(alu_write_in1), 32'(cur.w1));
        chk("alu_write_in2", 32'(alu_write_in2), 32'(cur.w2));
        chk("alu_read", 32'(alu_read), 32'(cur.ar));
        if (cur.drv) chk("bus", 32'(out_to_bus), 32'(cur.bus));
        else         chk("bus_z", 32'(bus_is_z()), 32'd1);
        if (done)   n_done_seen++;
        if (cur.dn) n_done_exp++;
    end

    task automatic set_instr(input logic m, input logic w, input logic [OW-1:0] o,
                             input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [DW-1:0] im);
        start = 1'b1; mode = m; wb_en = w; op = o; ri = a; rj = b; imm = im;
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int d_cyc[$];
    int base;

    initial begin
        // Reset held: everything quiet.
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_z", 32'(bus_is_z()), 32'd1);
        #2 reset = 1'b1;

        // Reg-imm with writeback.
        @(negedge clk); set_instr(1'b1, 1'b1, 3'd3, 4'd2, 4'd0, 16'h00A5);
        @(negedge clk); start = 1'b0;
        chk("ri_c1_rd", 32'(reg_read), 32'h4);
        chk("ri_c1_w1", 32'(alu_write_in1), 32'd1);
        @(negedge clk);
        chk("ri_c2_bus", 32'(out_to_bus), 32'h00A5);
        chk("ri_c2_w2", 32'(alu_write_in2), 32'd1);
        @(negedge clk); chk("ri_c3_op", 32'(alu_op), 32'd3);
        @(negedge clk);
        chk("ri_c4_wr", 32'(reg_write), 32'h4);
        chk("ri_c4_ar", 32'(alu_read), 32'd1);
        @(negedge clk);
        chk("ri_c5_done", 32'(done), 32'd1);
        chk("ri_c5_err", 32'(err), 32'd0);
        @(negedge clk); chk("ri_c6_busy", 32'(busy), 32'd0);

        // Reg-reg, no writeback.
        set_instr(1'b0, 1'b0, 3'd5, 4'd1, 4'd3, 16'h1234);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("rr_c2_rd", 32'(reg_read), 32'h8);
        chk("rr_c2_bus_z", 32'(bus_is_z()), 32'd1);
        @(negedge clk); chk("rr_c3_wr", 32'(reg_write), 32'd0);
        @(negedge clk); chk("rr_c4_done", 32'(done), 32'd1);
        @(negedge clk); chk("rr_c5_busy", 32'(busy), 32'd0);

        // Out-of-range destination.
        set_instr(1'b1, 1'b1, 3'd1, 4'd5, 4'd0, 16'h0F0F);
        @(negedge clk); start = 1'b0;
        chk("er_c1_done", 32'(done), 32'd1);
        chk("er_c1_err", 32'(err), 32'd1);
        chk("er_c1_rd", 32'(reg_read), 32'd0);
        @(negedge clk); chk("er_c2_busy", 32'(busy), 32'd0);

        // Inputs and start churn while busy.
        set_instr(1'b1, 1'b1, 3'd3, 4'd2, 4'd0, 16'h00A5);
        base = n_done_seen;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b1; ri = IW'($urandom_range(0, 3)); imm = DW'($urandom) | 16'h1;
            if (i == 1) chk("st_c1_rd", 32'(reg_read), 32'h4);
            if (i == 2) chk("st_c2_bus", 32'(out_to_bus), 32'h00A5);
            if (i == 4) chk("st_c4_wr", 32'(reg_write), 32'h4);
        end
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("st_one_done", 32'(n_done_seen - base), 32'd1);

        // Async reset landing in EVAL.
        set_instr(1'b0, 1'b1, 3'd6, 4'd1, 4'd2, 16'h5555);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_in_eval", 32'(alu_out_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_op", 32'(alu_op), 32'd0);
        chk("ab_strobes", 32'({alu_out_en, alu_read, reg_write, reg_read}), 32'd0);
        chk("ab_bus_z", 32'(bus_is_z()), 32'd1);
        @(negedge clk); #2 reset = 1'b1;
        base = n_done_seen;
        repeat (6) @(negedge clk);
        chk("ab_no_done", 32'(n_done_seen - base), 32'd0);
        set_instr(1'b1, 1'b1, 3'd2, 4'd3, 4'd0, 16'hBEEF);
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ab_restart_done", 32'(n_done_seen - base), 32'd1);

        // Back-to-back with start held.
        set_instr(1'b0, 1'b1, 3'd4, 4'd0, 4'd1, 16'h0001);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) d_cyc.push_back(i);
            mode = 1'($urandom); op = OW'($urandom);
            ri = IW'($urandom_range(0, 3)); rj = IW'($urandom_range(0, 3));
            imm = DW'($urandom) | 16'h1;
        end
        idle_cycles(8);
        chk("b2b_count", 32'(d_cyc.size() >= 6), 32'd1);
        for (int k = 1; k < d_cyc.size(); k++)
            chk("b2b_period", 32'(d_cyc[k] - d_cyc[k-1]), 32'd6);

        // Random traffic with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            mode = 1'($urandom); wb_en = 1'($urandom); op = OW'($urandom);
            ri = IW'($urandom_range(0, 5)); rj = IW'($urandom_range(0, 5));
            imm = DW'($urandom) | 16'h1;
            if ($urandom_range(0, 59) == 0) begin
                #2 reset = 1'b0;
                #1 chk("rnd_rst_busy", 32'(busy), 32'd0);
                @(negedge clk); #2 reset = 1'b1;
            end
        end
        idle_cycles(8);
        chk("done_total", 32'(n_done_seen), 32'(n_done_exp));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_exec_fsm.md
# alu_exec_fsm

Parametrised ALU instruction sequencer. It drives the shared 16-bit-class data bus, the register-file read/write strobes and the ALU control strobes to execute one ALU instruction per `start`. It supports register-register (`Ri op Rj -> Ri`) and register-immediate (`Ri op imm -> Ri`) forms, an optional no-writeback (flags-only) variant and an out-of-range register check. It sits beside the other instruction FSMs under the control unit and shares the bus and register strobes with them.

## Interface
- `DATA_W`, 16: bus and immediate width.
- `NREG`, 4: number of registers addressed; any value 2..16.
- `IDX_W`, 4: register index width; must be ≥ clog2(NREG).
- `OPC_W`, 3: ALU opcode width.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: instruction request; sampled only in IDLE.
- `mode`  in  1: 0 = register-register, 1 = register-immediate.
- `wb_en`  in  1: 1 = write the result to Ri; 0 = evaluate only, no writeback.
- `op`  in  OPC_W: ALU operation.
- `ri`, `rj`  in  IDX_W each: destination/source 1 and source 2 indices; `rj` is ignored when `mode`=1.
- `imm`  in  DATA_W: immediate operand.
- `reg_read`  out  NREG: one-hot register read enables.
- `reg_write`  out  NREG: one-hot register write enables.
- `alu_op`  out  OPC_W: opcode presented to the ALU.
- `alu_out_en`, `alu_write_in1`, `alu_write_in2`, `alu_read`  out  1 each: ALU strobes.
- `out_to_bus`  out  DATA_W: tri-state; drives `imm` only when enabled, otherwise all-Z.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid with `done`; 1 = index out of range.

## Operation
- States: IDLE, IN1, IN2, EVAL, OUT, FIN.
- All outputs are decoded from the registered state and the captured fields only. There are no latches, and every output is fully assigned in every state.
- Capture: on a `start`=1 edge in IDLE, the block latches `mode`, `wb_en`, `op`, `ri`, `rj` and `imm`. Input changes after capture are ignored until the next IDLE.
- Range check at capture: an error exists when `ri` ≥ NREG, or when `mode`=0 and `rj` ≥ NREG.
- Transitions:
  - IDLE→IN1 on `start` with no error.
  - IDLE→FIN on `start` with an error; `err` is latched to 1.
  - IN1→IN2→EVAL unconditionally.
  - EVAL→OUT when wb_en=1; EVAL→FIN when wb_en=0.
  - OUT→FIN.
  - FIN→IDLE.
- Outputs per state (anything not listed is 0, and the bus is Z):
  - IN1: `reg_read[ri]`=1, `alu_write_in1`=1.
  - IN2, mode=0: `reg_read[rj]`=1, `alu_write_in2`=1.
  - IN2, mode=1: `out_to_bus`=imm, `alu_write_in2`=1.
  - EVAL: `alu_out_en`=1, `alu_op`=op. `alu_op` is 0 in all other states.
  - OUT: `alu_read`=1, `reg_write[ri]`=1.
  - FIN: `done`=1. `err` is 1 if an error was latched; `err` is 0 outside FIN.
- ri = rj in reg-reg mode is legal: the same register is read twice.
- `start` while `busy` is ignored and not queued.
- `reg_read` and `reg_write` are never both non-zero, and each has at most one bit set.
- The block drives the bus only in IN2 with mode=1, so it never contends with register reads.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE immediately, including mid-instruction.
  - All outputs go to 0 and `out_to_bus` goes to Z within the reset assertion, with no clock needed.
  - Captured fields and `err` are cleared.
  - No `done` is produced for an aborted instruction.
- Reset release: the first edge with `reset`=1 may sample `start`.
- Latency, with `start` sampled at edge 0:
  - With writeback: IN1 in cycle 1, IN2 in cycle 2, EVAL in cycle 3, OUT in cycle 4, `done` in cycle 5. Back in IDLE at cycle 6; the earliest next start is sampled at edge 6.
  - wb_en=0: `done` in cycle 4.
  - Error: `done` with `err`=1 in cycle 1.
- `busy` rises in the cycle after the sampling edge and falls together with the end of `done`.

## Test plan
- Reg-imm (NREG=4, mode=1, ri=2, op=3, imm=16'h00A5, wb_en=1):
  - cycle 1: `reg_read`=4'b0100.
  - cycle 2: bus=16'h00A5, `alu_write_in2`=1.
  - cycle 3: `alu_op`=3.
  - cycle 4: `reg_write`=4'b0100, `alu_read`=1.
  - cycle 5: `done`=1, `err`=0.
  - Bus is Z in every other cycle.
- Reg-reg (ri=1, rj=3, wb_en=0):
  - cycle 2: `reg_read`=4'b1000, bus Z.
  - `reg_write` stays 0 throughout.
  - `done` in cycle 4.
- Error (NREG=3, ri=3):
  - cycle 1: `done`=1, `err`=1.
  - No read/write/ALU strobe at any point.
- Input stability and start filtering: change `ri`/`imm` and pulse `start` during cycles 1–4. Strobes must still follow the captured values, and exactly one `done` is produced.
- Reset during EVAL: drive `reset`=0 between edges. All outputs must go to 0 and the bus to Z immediately. After release, no `done` appears, and a new start completes normally.
- Back-to-back: hold `start`=1 continuously. A `done` must appear every 6 cycles, with `busy`=0 for exactly one cycle between instructions.
